// File: rtl/sr_fifo_pkg.sv
// ============================================================================
// Module   : sr_fifo_pkg
// Brief    : Occupancy-update encoding shared by the sr_fifo queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sr_fifo_pkg;

   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_INC  = 2'd1,
      CNT_DEC  = 2'd2
   } cnt_op_e;

   // Simultaneous push and pop leave occupancy unchanged.
   function automatic cnt_op_e cnt_op(input logic push, input logic pop);
      cnt_op_e op;
      op = CNT_HOLD;
      if (push && !pop) begin
         op = CNT_INC;
      end else if (pop && !push) begin
         op = CNT_DEC;
      end
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sr_fifo.sv
// ============================================================================
// Module   : sr_fifo
// Brief    : Single-clock data FIFO with zero-latency head read and sticky
//            overflow/underflow flags, coupling the sr_cpu datapath to a queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_fifo
   import sr_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   localparam int PTR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  writeEnable,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic                  readEnable,
   output logic [DATA_WIDTH-1:0] readData,
   output logic                  full,
   output logic                  empty,
   output logic [PTR_WIDTH:0]    count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [PTR_WIDTH:0] C_DEPTH = (PTR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_WIDTH-1:0]  r_wr_ptr;
   logic [PTR_WIDTH-1:0]  r_rd_ptr;
   logic [PTR_WIDTH:0]    r_count;
   logic                  r_overflow;
   logic                  r_underflow;

   logic    w_full;
   logic    w_empty;
   logic    w_push;
   logic    w_pop;
   cnt_op_e w_cnt_op;

   assign w_full   = (r_count == C_DEPTH);
   assign w_empty  = (r_count == '0);
   // A full FIFO still accepts a push when the head is popped in the same cycle.
   assign w_push   = writeEnable & (~w_full | readEnable);
   assign w_pop    = readEnable & ~w_empty;
   assign w_cnt_op = cnt_op(w_push, w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case (w_cnt_op)
            CNT_INC: r_count <= r_count + 1'b1;
            CNT_DEC: r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (writeEnable && w_full && !readEnable) begin
            r_overflow <= 1'b1;
         end
         if (readEnable && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   // Storage is deliberately left unreset; readData masks it while empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= writeData;
      end
   end

   assign readData  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign full      = w_full;
   assign empty     = w_empty;
   assign count     = r_count;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_sr_fifo.sv
// ============================================================================
// Module   : tb_sr_fifo
// Brief    : Scoreboard bench for sr_fifo (DEPTH=8, DATA_WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int PW    = $clog2(DEPTH);

   logic          clk         = 1'b0;
   logic          rst_n       = 1'b0;
   logic          writeEnable = 1'b0;
   logic [DW-1:0] writeData   = '0;
   logic          readEnable  = 1'b0;
   logic [DW-1:0] readData;
   logic          full;
   logic          empty;
   logic [PW:0]   count;
   logic          overflow;
   logic          underflow;

   sr_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .writeEnable (writeEnable),
      .writeData   (writeData),
      .readEnable  (readEnable),
      .readData    (readData),
      .full        (full),
      .empty       (empty),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 clk = ~clk;

   int            n_vec = 0;
   int            n_err = 0;
   logic [DW-1:0] sb[$];
   logic          exp_ovf = 1'b0;
   logic          exp_unf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic post_check();
      logic [DW-1:0] head;
      head = (sb.size() > 0) ? sb[0] : '0;
      chk("count",     32'(count),     32'(sb.size()));
      chk("empty",     32'(empty),     32'(sb.size() == 0));
      chk("full",      32'(full),      32'(sb.size() == DEPTH));
      chk("overflow",  32'(overflow),  32'(exp_ovf));
      chk("underflow", 32'(underflow), 32'(exp_unf));
      chk("head",      readData,       head);
   endtask

   // Called at posedge+1; returns at the following posedge+1.
   task automatic op(input logic we, input logic [DW-1:0] wd, input logic re);
      logic          mpush;
      logic          mpop;
      logic [DW-1:0] exp_head;
      writeEnable = we;
      writeData   = wd;
      readEnable  = re;
      #2;
      mpop  = re && (sb.size() > 0);
      mpush = we && ((sb.size() < DEPTH) || re);
      if (re) begin
         if (mpop) begin
            exp_head = sb.pop_front();
            chk("pop_data", readData, exp_head);
         end else begin
            chk("pop_empty_data", readData, '0);
         end
      end
      if (we && !mpush) exp_ovf = 1'b1;
      if (re && !mpop)  exp_unf = 1'b1;
      if (mpush) sb.push_back(wd);
      @(posedge clk);
      #1;
      writeEnable = 1'b0;
      readEnable  = 1'b0;
      post_check();
   endtask

   // Reset is asserted between edges; outputs must clear without a clock.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_empty",     32'(empty),     32'd1);
      chk("rst_full",      32'(full),      32'd0);
      chk("rst_count",     32'(count),     32'd0);
      chk("rst_readData",  readData,       32'd0);
      chk("rst_overflow",  32'(overflow),  32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      sb.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      post_check();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      op(1'b0, '0, 1'b0);

      // In-order delivery of three entries.
      op(1'b1, 32'h11, 1'b0);
      op(1'b1, 32'h22, 1'b0);
      op(1'b1, 32'h33, 1'b0);
      repeat (3) op(1'b0, '0, 1'b1);
      op(1'b0, '0, 1'b0);

      // Overfill: the ninth push is dropped.
      do_reset();
      for (int i = 0; i < 9; i++) op(1'b1, 32'h100 + 32'(i), 1'b0);
      repeat (8) op(1'b0, '0, 1'b1);

      // Full with simultaneous push and pop.
      do_reset();
      for (int i = 0; i < 8; i++) op(1'b1, 32'h100 + 32'(i), 1'b0);
      op(1'b1, 32'hAA, 1'b1);
      repeat (7) op(1'b0, '0, 1'b1);
      chk("aa_at_head", readData, 32'hAA);
      op(1'b0, '0, 1'b1);

      // Pop while empty with a simultaneous push.
      do_reset();
      op(1'b1, 32'h55, 1'b1);
      chk("unf_set", 32'(underflow), 32'd1);
      op(1'b0, '0, 1'b1);

      // Reset in the middle of a populated stream.
      do_reset();
      for (int i = 0; i < 4; i++) op(1'b1, 32'hC0 + 32'(i), 1'b0);
      do_reset();

      // Pointer wrap with steady occupancy of three.
      for (int i = 0; i < 3; i++) op(1'b1, 32'h200 + 32'(i), 1'b0);
      for (int i = 0; i < 20; i++) op(1'b1, 32'h300 + 32'(i), 1'b1);
      chk("wrap_count", 32'(count), 32'd3);
      repeat (3) op(1'b0, '0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
